// File: rtl/victim_tag_cam_pkg.sv
// Shared constants and types for the L1 victim tag store.
// Top-level users instantiate victim_tag_cam with VIC_ENTRIES / VIC_TAG_W and these typedefs.
package victim_tag_cam_pkg;

  localparam int VIC_ENTRIES = 4;
  localparam int VIC_TAG_W   = 12;

  typedef logic [VIC_TAG_W-1:0]            lc3b_c_vic_tag;
  typedef logic [$clog2(VIC_ENTRIES)-1:0]  lc3b_c_vic_index;

endpackage

// File: rtl/victim_lru_age.sv
// True-LRU age vector: age 0 is MRU, age ENTRIES-1 is LRU; ages stay a permutation.
module victim_lru_age
  import victim_tag_cam_pkg::*;
#(
  parameter int ENTRIES = VIC_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             promote,
  input  logic [IDX_W-1:0] promote_way,
  output logic [IDX_W-1:0] lru_way
);

  logic [IDX_W-1:0] age_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
    end else if (promote) begin
      // Only entries younger than the promoted one age; older entries keep their slot.
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == promote_way)
          age_q[i] <= '0;
        else if (age_q[i] < age_q[promote_way])
          age_q[i] <= age_q[i] + IDX_W'(1);
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (age_q[i] == IDX_W'(ENTRIES-1)) lru_way = IDX_W'(i);
  end

endmodule

// File: rtl/victim_tag_cam.sv
// Fully-associative victim tag CAM with valid/dirty state and true-LRU replacement.
// Optional VICTIM_TAG_STATS_EN adds saturating hit_count / miss_count outputs.
module victim_tag_cam
  import victim_tag_cam_pkg::*;
#(
  parameter int ENTRIES = VIC_ENTRIES,
  parameter int TAG_W   = VIC_TAG_W,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_way,
  input  logic               touch,
  input  logic               invalidate,
  input  logic               insert,
  input  logic [TAG_W-1:0]   insert_tag,
  input  logic               insert_dirty,
  output logic [IDX_W-1:0]   repl_way,
  output logic               repl_valid,
  output logic               repl_dirty,
  output logic [TAG_W-1:0]   repl_tag,
  output logic [ENTRIES-1:0] valid_vec
`ifdef VICTIM_TAG_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] dirty_q;

  logic [ENTRIES-1:0] hit_vec;
  logic [ENTRIES-1:0] ins_vec;
  logic               ins_hit;
  logic [IDX_W-1:0]   ins_way;
  logic [IDX_W-1:0]   free_way;
  logic [IDX_W-1:0]   lru_way;
  logic [IDX_W-1:0]   tgt_way;
  logic               promote_en;
  logic [IDX_W-1:0]   promote_way;

  always_comb begin
    hit_vec  = '0;
    ins_vec  = '0;
    hit_way  = '0;
    ins_way  = '0;
    free_way = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_tag);
      ins_vec[i] = valid_q[i] && (tag_q[i] == insert_tag);
    end
    // Descending scan so the lowest matching / free index wins.
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (hit_vec[i])  hit_way  = IDX_W'(i);
      if (ins_vec[i])  ins_way  = IDX_W'(i);
      if (!valid_q[i]) free_way = IDX_W'(i);
    end
    hit     = |hit_vec;
    ins_hit = |ins_vec;

    repl_way   = (&valid_q) ? lru_way : free_way;
    repl_valid = valid_q[repl_way];
    repl_dirty = dirty_q[repl_way];
    repl_tag   = tag_q[repl_way];
    valid_vec  = valid_q;

    // An insert of a resident tag merges into that entry instead of allocating.
    tgt_way     = ins_hit ? ins_way : repl_way;
    promote_en  = insert || (touch && hit && !invalidate);
    promote_way = insert ? tgt_way : hit_way;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      if (invalidate && hit) begin
        valid_q[hit_way] <= 1'b0;
        dirty_q[hit_way] <= 1'b0;
      end
      // Written after the invalidate so an insert to the same way takes precedence.
      if (insert) begin
        valid_q[tgt_way] <= 1'b1;
        if (ins_hit) begin
          dirty_q[tgt_way] <= dirty_q[tgt_way] | insert_dirty;
        end else begin
          tag_q[tgt_way]   <= insert_tag;
          dirty_q[tgt_way] <= insert_dirty;
        end
      end
    end
  end

  victim_lru_age #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_lru (
    .clk         (clk),
    .reset       (reset),
    .promote     (promote_en),
    .promote_way (promote_way),
    .lru_way     (lru_way)
  );

`ifdef VICTIM_TAG_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (touch) begin
      if (hit) hit_count  <= sat_inc16(hit_count);
      else     miss_count <= sat_inc16(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_victim_tag_cam.sv
// Directed bench for victim_tag_cam (4 entries, 12-bit tags).
module tb_victim_tag_cam;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] lookup_tag = '0;
  logic        hit;
  logic [1:0]  hit_way;
  logic        touch = 1'b0;
  logic        invalidate = 1'b0;
  logic        insert = 1'b0;
  logic [11:0] insert_tag = '0;
  logic        insert_dirty = 1'b0;
  logic [1:0]  repl_way;
  logic        repl_valid;
  logic        repl_dirty;
  logic [11:0] repl_tag;
  logic [3:0]  valid_vec;
`ifdef VICTIM_TAG_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  victim_tag_cam #(.ENTRIES(4), .TAG_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag   (lookup_tag),
    .hit          (hit),
    .hit_way      (hit_way),
    .touch        (touch),
    .invalidate   (invalidate),
    .insert       (insert),
    .insert_tag   (insert_tag),
    .insert_dirty (insert_dirty),
    .repl_way     (repl_way),
    .repl_valid   (repl_valid),
    .repl_dirty   (repl_dirty),
    .repl_tag     (repl_tag),
    .valid_vec    (valid_vec)
`ifdef VICTIM_TAG_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [11:0] t, input logic d);
    insert = 1'b1; insert_tag = t; insert_dirty = d;
    step();
    insert = 1'b0; insert_dirty = 1'b0;
  endtask

  task automatic look(input logic [11:0] t);
    lookup_tag = t;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    look(12'h000);
    chk("rst_hit", hit, 0);
    chk("rst_hit_way", hit_way, 0);
    chk("rst_repl_way", repl_way, 0);
    chk("rst_repl_valid", repl_valid, 0);
    chk("rst_repl_dirty", repl_dirty, 0);
    chk("rst_repl_tag", repl_tag, 0);
    chk("rst_valid_vec", valid_vec, 4'b0000);

    // Fill: ages end at [3,2,1,0], entry 0 is LRU.
    ins(12'h111, 0); ins(12'h222, 0); ins(12'h333, 0); ins(12'h444, 0);
    chk("fill_valid_vec", valid_vec, 4'b1111);
    chk("fill_repl_way", repl_way, 0);
    chk("fill_repl_tag", repl_tag, 12'h111);
    chk("fill_repl_valid", repl_valid, 1);
    look(12'h333);
    chk("look333_hit", hit, 1);
    chk("look333_way", hit_way, 2);

    // Touch 111 -> ages [0,3,2,1], LRU entry 1.
    look(12'h111);
    chk("touch111_hit", hit, 1);
    chk("touch111_way", hit_way, 0);
    touch = 1'b1; step(); touch = 1'b0;
    chk("touch111_repl_way", repl_way, 1);
    chk("touch111_repl_tag", repl_tag, 12'h222);

    // Insert 555 dirty evicts entry 1 -> ages [1,0,3,2], LRU entry 2.
    ins(12'h555, 1);
    look(12'h555);
    chk("ins555_hit_way", hit_way, 1);
    look(12'h222);
    chk("ins555_evicted222", hit, 0);
    chk("ins555_repl_way", repl_way, 2);
    chk("ins555_repl_tag", repl_tag, 12'h333);

    // Invalidate 333 (entry 2).
    look(12'h333);
    chk("inv333_hit_way", hit_way, 2);
    invalidate = 1'b1; step(); invalidate = 1'b0;
    chk("inv333_valid_vec", valid_vec, 4'b1011);
    chk("inv333_repl_way", repl_way, 2);
    chk("inv333_repl_valid", repl_valid, 0);
    chk("inv333_repl_dirty", repl_dirty, 0);
    look(12'h333);
    chk("inv333_no_hit", hit, 0);

    // Touch 444 -> [2,1,3,0]; re-insert 555 clean -> merges, [2,0,3,1].
    look(12'h444);
    touch = 1'b1; step(); touch = 1'b0;
    ins(12'h555, 0);
    chk("dup555_valid_vec", valid_vec, 4'b1011);
    look(12'h555);
    chk("dup555_hit_way", hit_way, 1);

    // Insert 444 while invalidating 444: entry 3 stays valid -> [2,1,3,0].
    look(12'h444);
    invalidate = 1'b1;
    ins(12'h444, 0);
    invalidate = 1'b0;
    chk("insinv_valid_vec", valid_vec, 4'b1011);
    look(12'h444);
    chk("insinv_hit", hit, 1);
    chk("insinv_hit_way", hit_way, 3);

    // Fill entry 2 with 666 -> [3,2,0,1], LRU entry 0.
    ins(12'h666, 0);
    chk("ins666_valid_vec", valid_vec, 4'b1111);
    chk("ins666_repl_way", repl_way, 0);
    chk("ins666_repl_tag", repl_tag, 12'h111);

    // Touch 111 -> [0,3,1,2]; entry 1 (555) is LRU and still dirty.
    look(12'h111);
    touch = 1'b1; step(); touch = 1'b0;
    chk("lru555_repl_way", repl_way, 1);
    chk("lru555_repl_tag", repl_tag, 12'h555);
    chk("lru555_repl_dirty", repl_dirty, 1);
    chk("lru555_repl_valid", repl_valid, 1);

    // Touch + invalidate on 666 (entry 2): invalidated.
    look(12'h666);
    touch = 1'b1; invalidate = 1'b1; step(); touch = 1'b0; invalidate = 1'b0;
    chk("tchinv_valid_vec", valid_vec, 4'b1011);
    chk("tchinv_repl_way", repl_way, 2);

    // Insert 777 while touching 111: only entry 2 promoted -> [1,3,0,2], LRU 1.
    look(12'h111);
    touch = 1'b1;
    ins(12'h777, 0);
    touch = 1'b0;
    chk("instch_repl_way", repl_way, 1);
    chk("instch_repl_tag", repl_tag, 12'h555);

`ifdef VICTIM_TAG_STATS_EN
    reset = 1'b1; step(); reset = 1'b0;
    chk("stats_rst_hits", hit_count, 0);
    chk("stats_rst_miss", miss_count, 0);
    ins(12'h111, 0);
    look(12'h111);
    touch = 1'b1; step(); step(); step();
    look(12'h999);
    step(); step();
    touch = 1'b0;
    chk("stats_hits", hit_count, 3);
    chk("stats_miss", miss_count, 2);
`endif

    // Reset wins over a simultaneous insert.
    reset = 1'b1;
    ins(12'h999, 1);
    reset = 1'b0;
    chk("rstins_valid_vec", valid_vec, 4'b0000);
    look(12'h999);
    chk("rstins_hit", hit, 0);
    chk("rstins_repl_tag", repl_tag, 0);
`ifdef VICTIM_TAG_STATS_EN
    chk("rstins_hits", hit_count, 0);
    chk("rstins_miss", miss_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
